serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor that computes Diff = A - B - BorrowIn, one bit per clock, LSB first. It is the inverse-operation companion to the team's 1-bit full adder: one full-subtractor cell plus a borrow flip-flop replaces a ripple chain. It serves area-constrained datapaths that can accept WIDTH-cycle latency, and uses a Start/Busy/Done handshake.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough for WIDTH >= 2.
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - br, with the borrow out of this bit position.
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_next_o
);

    assign d_o       = a_i ^ b_i ^ br_i;
    assign br_next_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with a Start/Busy/Done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed Overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BorrowIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int             CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             cell_d, cell_br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ov_q, ov_d;
`endif

    full_subtractor_cell u_cell (
        .a_i       (a_sh_q[0]),
        .b_i       (b_sh_q[0]),
        .br_i      (br_q),
        .d_o       (cell_d),
        .br_next_o (cell_br_next)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ov_d    = ov_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    br_d    = BorrowIn;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                br_d   = cell_br_next;
                cnt_d  = cnt_q + 1'b1;
                // The last bit is folded straight into Diff so it is valid on entry to DONE.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ov_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ov_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ov_q    <= ov_d;
`endif
        end
    end

    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign Diff      = diff_q;
    assign BorrowOut = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign Overflow  = ov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases, reset abort,
// exhaustive cell check and 1000 random operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [W-1:0] A, B;
    logic         BorrowIn;
    logic         Busy, Done, BorrowOut;
    logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         Overflow;
`endif

    logic cell_a, cell_b, cell_br, cell_d, cell_bn;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_bout = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .BorrowIn  (BorrowIn),
        .Busy      (Busy),
        .Done      (Done),
        .Diff      (Diff),
        .BorrowOut (BorrowOut)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    full_subtractor_cell u_cell_chk (
        .a_i       (cell_a),
        .b_i       (cell_b),
        .br_i      (cell_br),
        .d_o       (cell_d),
        .br_next_o (cell_bn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; poke re-pulses Start with other operands while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input bit poke);
        int           full;
        logic [W-1:0] exp_diff;
        logic         exp_bo;
        full     = int'(a) - int'(b) - int'(bin);
        exp_diff = W'(full);
        exp_bo   = (full < 0);

        Start = 1'b1; A = a; B = b; BorrowIn = bin;
        tick();
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); BorrowIn = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy", 32'(Busy), 32'd1);
            check("done_early", 32'(Done), 32'd0);
            check("diff_hold", 32'(Diff), 32'(prev_diff));
            check("bout_hold", 32'(BorrowOut), 32'(prev_bout));
            if (poke && i == 2) begin
                Start = 1'b1; A = '1; B = '1; BorrowIn = 1'b0;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        Start = 1'b0;
        check("done", 32'(Done), 32'd1);
        check("busy_at_done", 32'(Busy), 32'd0);
        check("diff", 32'(Diff), 32'(exp_diff));
        check("borrow_out", 32'(BorrowOut), 32'(exp_bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("overflow", 32'(Overflow),
              32'((a[W-1] != b[W-1]) && (exp_diff[W-1] != a[W-1])));
`endif
        prev_diff = exp_diff;
        prev_bout = exp_bo;
        tick();
        check("done_pulse", 32'(Done), 32'd0);
        check("idle_busy", 32'(Busy), 32'd0);
        check("diff_after", 32'(Diff), 32'(prev_diff));
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; A = '0; B = '0; BorrowIn = 1'b0;
        cell_a = 1'b0; cell_b = 1'b0; cell_br = 1'b0;

        // Exhaustive cell check against plain arithmetic.
        for (int v = 0; v < 8; v++) begin
            int r;
            cell_a = v[2]; cell_b = v[1]; cell_br = v[0];
            #1;
            r = int'(cell_a) - int'(cell_b) - int'(cell_br);
            check("cell_d", 32'(cell_d), 32'(r & 1));
            check("cell_bn", 32'(cell_bn), 32'(r < 0));
        end

        tick(); tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(BorrowOut), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst_ov", 32'(Overflow), 32'd0);
`endif
        rst = 1'b0;
        tick();

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b0, 1'b1);
        check("ignored_start_busy", 32'(Busy), 32'd0);

        // Abort on the 4th RUN cycle.
        Start = 1'b1; A = 8'h10; B = 8'h01; BorrowIn = 1'b0;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        check("pre_abort_busy", 32'(Busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_bout", 32'(BorrowOut), 32'd0);
        prev_diff = '0;
        prev_bout = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            check("abort_no_done", 32'(Done), 32'd0);
            tick();
        end
        run_op(8'h10, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
